// File: rtl/clk_count_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_count_ctrl_if
// Avalon-MM register bus between the Nios II and the cycle-count controller.
//   address   [1:0]  word address
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] read data, registered in the slave (one-cycle latency)
// Modports: master (CPU side / bench), slave (controller side).
// ---------------------------------------------------------------------------
interface clk_count_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/clk_count_ctrl.sv
// ---------------------------------------------------------------------------
// clk_count_ctrl
// Cycle-count controller feeding the Nios II PIO input port. Owns a counter
// that either free-runs between CPU start/stop commands or measures a window
// of WINDOW event strobes after an arming strobe. The result is held in a
// snapshot register that only changes on completion, stop, clear or reset.
//
// Ports:
//   clk        system clock (100 MHz)
//   reset_n    asynchronous active-low reset
//   avs        Avalon-MM slave (address/write/writedata/readdata)
//   trig       single-cycle event strobe, synchronous to clk
//   count_out  snapshot value to the PIO in_port
//   busy       high while armed or running
//   done_irq   sticky completion flag (level)
//
// Register map (write):  0 CTRL {mode, clear, stop, start}, 1 WINDOW
// Register map (read):   0 STATUS {overflow, done_irq, state}, 1 WINDOW,
//                        2 snapshot, 3 live counter
// ---------------------------------------------------------------------------
module clk_count_ctrl #(
  parameter int WIDTH = 32,
  parameter int WIN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  clk_count_ctrl_if.slave       avs,
  input  logic                  trig,
  output logic [WIDTH-1:0]      count_out,
  output logic                  busy,
  output logic                  done_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   counter_q, counter_d;
  logic [WIDTH-1:0]   snapshot_q, snapshot_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [WIN_W-1:0]   remaining_q, remaining_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic [31:0]        readdata_q, readdata_d;

  // Command decode. stop dominates start within the same CTRL write.
  logic ctrl_wr, win_wr;
  logic cmd_start, cmd_stop, cmd_clear, cmd_any;

  assign ctrl_wr   = avs.write && (avs.address == 2'd0);
  assign win_wr    = avs.write && (avs.address == 2'd1);
  assign cmd_stop  = ctrl_wr && avs.writedata[1];
  assign cmd_start = ctrl_wr && avs.writedata[0] && !avs.writedata[1];
  assign cmd_clear = ctrl_wr && avs.writedata[2];
  assign cmd_any   = ctrl_wr && (avs.writedata[2:0] != 3'd0);

  // Only a handful of writedata bits are decoded; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^avs.writedata;

  logic [WIDTH-1:0] counter_inc;
  logic             counter_wrap;

  assign counter_inc  = counter_q + WIDTH'(1);
  assign counter_wrap = &counter_q;

  // Next-state / datapath
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    snapshot_d  = snapshot_q;
    window_d    = window_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    mode_d      = mode_q;

    if (cmd_stop) begin
      unique case (state_q)
        RUN: begin
          // Snapshot is the pre-increment count; the counter still ticks
          // on this edge and then holds in IDLE.
          snapshot_d = counter_q;
          counter_d  = counter_inc;
          if (counter_wrap) overflow_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
        ARM:     state_d = IDLE;
        default: ;
      endcase
    end else if (cmd_start) begin
      counter_d  = '0;
      overflow_d = 1'b0;
      done_d     = 1'b0;
      if (!avs.writedata[3]) begin
        state_d = RUN;
      end else if (window_q == '0) begin
        // Empty window completes immediately without ever going busy.
        state_d    = DONE;
        snapshot_d = '0;
        done_d     = 1'b1;
      end else begin
        state_d = ARM;
      end
    end else if (!cmd_any) begin
      // Any CTRL command cycle takes precedence over trig/counting.
      unique case (state_q)
        ARM: begin
          if (trig) begin
            counter_d   = '0;
            remaining_d = window_q;
            state_d     = RUN;
          end
        end
        RUN: begin
          counter_d = counter_inc;
          if (counter_wrap) overflow_d = 1'b1;
          if (mode_q && trig) begin
            remaining_d = remaining_q - WIN_W'(1);
            if (remaining_q == WIN_W'(1)) begin
              snapshot_d = counter_inc;
              done_d     = 1'b1;
              state_d    = DONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (cmd_clear) begin
      snapshot_d = '0;
      // With start, the start path already reset counter/overflow/done.
      if (!cmd_start) begin
        counter_d  = '0;
        overflow_d = 1'b0;
        done_d     = 1'b0;
        if (state_d == DONE) state_d = IDLE;
      end
    end

    if (ctrl_wr) mode_d = avs.writedata[3];
    if (win_wr)  window_d = avs.writedata[WIN_W-1:0];
  end

  // Read mux, registered below; address is sampled every cycle.
  always_comb begin
    readdata_d = '0;
    unique case (avs.address)
      2'd0:    readdata_d = {28'd0, overflow_q, done_q, state_q};
      2'd1:    readdata_d[WIN_W-1:0] = window_q;
      2'd2:    readdata_d[WIDTH-1:0] = snapshot_q;
      default: readdata_d[WIDTH-1:0] = counter_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      snapshot_q  <= '0;
      window_q    <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      snapshot_q  <= snapshot_d;
      window_q    <= window_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      readdata_q  <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign count_out    = snapshot_q;
  assign done_irq     = done_q;
  assign busy         = (state_q == ARM) || (state_q == RUN);

endmodule

// File: doc/clk_count_ctrl.md
Name: clk_count_ctrl

Overview:
- Controller for the 100 MHz cycle-count datapath that the Nios II reads through its 32-bit PIO input port.
- Owns the free-running/gated cycle counter and sequences measurements: free-run start/stop, or a window of N external event strobes (e.g. audio sample strobes for AGC timing).
- Drives the PIO input with a stable snapshot.
- Configured by the CPU over a small Avalon-MM slave with registered reads.

Parameters:
WIDTH, 32, counter/snapshot width (≤32; readdata zero-extended)
WIN_W, 16, width of the event-window length register

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  reset
address  in  2  Avalon word address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
trig  in  1  single-cycle event strobe, already synchronous to clk
count_out  out  WIDTH  snapshot value, to PIO in_port
busy  out  1  high in ARM or RUN
done_irq  out  1  sticky completion flag (level)

Behaviour:
- Reset: asynchronous, active-low reset_n; clock clk; every flop responds to reset immediately.
- Reset values: readdata=0, count_out=0, busy=0, done_irq=0, counter=0, window=0, overflow=0, mode=0, state=IDLE.
- Register map, write side:
  - addr0 CTRL: bit0 start, bit1 stop, bit2 clear, bit3 mode (0 free, 1 window); mode is latched on every CTRL write.
  - addr1 WINDOW: bits[WIN_W-1:0].
  - addr2, addr3: read-only; writes ignored.
- Register map, read side:
  - addr0 STATUS = {28'b0, overflow, done_irq, state[1:0]}.
  - addr1 WINDOW.
  - addr2 snapshot.
  - addr3 live counter.
- readdata updates every clk from address (no read strobe, one-cycle latency).
- State encoding: IDLE=0, ARM=1, RUN=2, DONE=3.
- start, from any state:
  - counter<=0, overflow<=0, done_irq<=0.
  - free mode -> RUN.
  - window mode -> ARM; if WINDOW==0 -> DONE instead, with snapshot<=0 and done_irq<=1.
- ARM: on trig, counter<=0, remaining<=WINDOW, -> RUN.
- RUN:
  - counter<=counter+1 every cycle; wraps at 2^WIDTH-1 -> 0 and sets sticky overflow.
  - Window mode: each trig decrements remaining. Trig with remaining==1 -> snapshot<=counter+1, done_irq<=1, -> DONE.
  - Result: snapshot = clk cycles between the first (arming) trig and the WINDOW-th subsequent trig.
- stop:
  - In RUN: snapshot<=counter (value before the increment), -> IDLE, done_irq<=1.
  - In ARM: -> IDLE, snapshot unchanged.
  - In IDLE/DONE: no effect.
- clear: counter<=0, snapshot<=0, overflow<=0, done_irq<=0; state unchanged.
- DONE: counter holds; stays until start or clear. clear in DONE -> IDLE.
- Simultaneous events:
  - stop+start in one write: stop wins, start ignored.
  - clear+start: treated as start; snapshot also cleared.
  - stop write in the same cycle as a completing trig: stop wins; snapshot<=counter, no window completion.
  - Trig in IDLE/DONE: ignored.
- count_out = snapshot register; changes only on completion, stop, clear or reset, never mid-measurement.
- busy is combinational from state.

Test Plan:
- Reset mid-RUN (counter=500) -> all outputs 0 in the same cycle, state IDLE; read addr3 next cycle returns 0.
- Free mode: write CTRL=0x1, 100 cycles later write CTRL=0x2 -> count_out=100±1 cycle per documented counter timing (exact value checked against model); done_irq=1; STATUS reads 0x4.
- Window mode: WINDOW=2, CTRL=0x9, trig at cycles t, t+48, t+96 -> count_out=96, done_irq=1, state DONE; further trig leaves count_out=96.
- WINDOW=0, CTRL=0x9 -> next cycle state DONE, count_out=0, done_irq=1, busy never asserted.
- WIDTH=8 build, free run 300 cycles then stop -> count_out=300 mod 256 = 44, STATUS overflow bit=1; clear -> count_out=0, overflow=0.
- Stop written in the same cycle as the completing trig (WINDOW=1) -> state IDLE, count_out=counter value at stop, no DONE transition.
